seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial sequence detector. Replaces the fixed-pattern detector.
- Samples one bit per enabled clock on w and asserts z when the last len bits equal a programmable pattern.
- Pattern, length and overlap mode are runtime-configurable through a load strobe.
- Sits between a serial bit source and control logic that consumes single-cycle match pulses.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of len port; must hold MAX_LEN.
- CNT_W, 8: width of match_count (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- w  input  1  serial data bit, sampled when en=1.
- en  input  1  bit-valid qualifier; en=0 holds all state.
- cfg_load  input  1  latch pattern/len/overlap; clears history.
- pattern  input  MAX_LEN  target sequence. pattern[len-1] is the oldest bit and pattern[0] is the newest bit.
- len  input  LEN_W  pattern length; 0 = detector disabled.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- z  output  1  registered match pulse.
- match_count  output  CNT_W  saturating match counter (MATCH_COUNT_EN only).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset; it is sampled only on the rising edge of clk.
- Reset values:
  - z=0, history=0, fill=0.
  - cfg_pattern=0, cfg_len=0, cfg_overlap=1.
  - match_count=0.
  - With cfg_len=0 after reset, the detector is idle until the first cfg_load.
- Config:
  - On cfg_load=1: cfg_pattern<=pattern, cfg_overlap<=overlap, cfg_len<=min(len,MAX_LEN).
  - cfg_load also clears history and fill, and forces z=0 that cycle. The w bit in that cycle is discarded.
  - cfg_load has priority over en.
  - reset has priority over everything.
- Shift:
  - When en=1 and cfg_load=0: hist_next={history[MAX_LEN-2:0],w}, with the newest bit in hist_next[0].
  - fill_next=min(fill+1,MAX_LEN).
- Match:
  - match = (cfg_len!=0) && (fill_next>=cfg_len) && ((hist_next ^ cfg_pattern) & mask(cfg_len))==0.
  - mask(n) has the low n bits set.
- z latency: z<=match on the same edge that shifts in the completing bit. z is high for exactly one cycle per match and low on any cycle with en=0.
- Overlap=1: history and fill keep shifting normally after a match.
- Overlap=0: on a match, fill<=0 (history contents retained but invalid). The next match needs cfg_len fresh bits.
- en=0: history, fill and config hold; z<=0.
- Reset mid-stream: all partial progress is lost and the next match needs cfg_len new bits. Configuration returns to reset values.
- len>MAX_LEN: clamped to MAX_LEN, no error flag.
- len=1: z follows (w==cfg_pattern[0]) each enabled cycle, delayed one edge. Overlap mode is irrelevant.

Optional Feature:
- Macro SEQ_DETECTOR_MATCH_COUNT_EN.
- Defined:
  - match_count increments by 1 on each cycle where z is set. It saturates at 2^CNT_W-1.
  - It is cleared by reset and by cfg_load.
- Undefined: match_count port is present but tied to 0, and no counter logic is built.

Test Plan:
- Reset, load pattern=8'b0000_1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 with en=1 -> z pulses after bit 4 and after bit 7; match_count=2.
- Same stream with overlap=0 -> z pulses only after bit 4, because bits 5-7 give fill 3<4; match_count=1.
- Pattern 1011, len=4; drive 1,0,1, then en=0 for 3 cycles with w toggling, then en=1 with w=1 -> z=0 during the gap and a single z pulse after the final bit.
- Stream 1,0,1, then assert reset for one cycle, then 1 -> no z; the next z requires a full 1,0,1,1 after cfg_load. The config cleared by reset must be reloaded.
- len=12 with MAX_LEN=8, pattern=8'hFF; stream 8 ones -> z after the 8th one (clamped length), then z every cycle while w=1 and overlap=1.
- MATCH_COUNT_EN with CNT_W=2, pattern len=1 = 1, 6 consecutive ones -> match_count goes 1,2,3,3,3,3; cfg_load -> 0.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial sequence detector.
// Shifts one bit per enabled clock into a history register and pulses z for
// one cycle when the newest cfg_len bits equal cfg_pattern[cfg_len-1:0]
// (pattern[cfg_len-1] oldest, pattern[0] newest). Pattern, length and
// overlap mode are latched by cfg_load, which also restarts detection.
//
// Optional build macro: SEQ_DETECTOR_MATCH_COUNT_EN
//   defined   -> match_count is a saturating count of z pulses since the
//                last reset or cfg_load.
//   undefined -> match_count is tied to zero and no counter is built.
//
// Stream handshake: en is a pure valid qualifier with no back-pressure.
// A bit on w is consumed on every rising edge where en=1 and cfg_load=0.
// With en=0 nothing is consumed, all state holds and z is driven low.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               w,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   cfg_len;
    logic [LEN_W-1:0]   len_clamped;
    logic               cfg_overlap;
    logic               match;

    // Next history/fill, the compare mask and the match decision for this edge.
    always_comb begin
        hist_next   = {history[MAX_LEN-2:0], w};
        fill_next   = (fill >= MAX_LEN_L) ? MAX_LEN_L : fill + LEN_W'(1);
        len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
        mask        = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(cfg_len));
        end
        match = (cfg_len != '0) && (fill_next >= cfg_len) &&
                (((hist_next ^ cfg_pattern) & mask) == '0);
    end

    // Config latch, bit history, fill count and registered match pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            history     <= '0;
            fill        <= '0;
            cfg_pattern <= '0;
            cfg_len     <= '0;
            cfg_overlap <= 1'b1;
            z           <= 1'b0;
        end else if (cfg_load) begin
            // The w bit of a load cycle is intentionally dropped.
            cfg_pattern <= pattern;
            cfg_len     <= len_clamped;
            cfg_overlap <= overlap;
            history     <= '0;
            fill        <= '0;
            z           <= 1'b0;
        end else if (en) begin
            history <= hist_next;
            // Non-overlapping mode: a match consumes its bits, so validity
            // restarts from zero while the stale history bits are ignored.
            fill    <= (match && !cfg_overlap) ? '0 : fill_next;
            z       <= match;
        end else begin
            z <= 1'b0;
        end
    end

`ifdef SEQ_DETECTOR_MATCH_COUNT_EN
    logic [CNT_W-1:0] count;

    // Saturating count of match pulses, incremented on the edge that sets z.
    always_ff @(posedge clk) begin
        if (reset || cfg_load) begin
            count <= '0;
        end else if (en && match && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign match_count = count;
`else
    assign match_count = '0;
`endif

endmodule
